// File: rtl/fifo_pkg.sv
// fifo_pkg: default FIFO sizing and a constant log2 helper
package fifo_pkg;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_DEPTH = 8;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/fifo_mem.sv
// fifo_mem: storage array, one write port and one registered read port, no reset
module fifo_mem #(
  parameter int DATA_W = 32,
  parameter int AW = 3
) (
  input  logic              Clk,
  input  logic              we,
  input  logic [AW-1:0]     wa,
  input  logic [DATA_W-1:0] wd,
  input  logic              re,
  input  logic [AW-1:0]     ra,
  output logic [DATA_W-1:0] rd
);
  logic [DATA_W-1:0] mem [2**AW];
  // Write-through-free array: a read at the write address returns the old word
  always_ff @(posedge Clk) begin
    if (we) mem[wa] <= wd;
    if (re) rd <= mem[ra];
  end
endmodule

// File: rtl/param_fifo_buffer.sv
// param_fifo_buffer: synchronous FIFO with occupancy flags; PARAM_FIFO_ERR_FLAGS_EN adds sticky OVERFLOW/UNDERFLOW
module param_fifo_buffer
  import fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH = DEF_DEPTH,
  parameter int AF_LEVEL = DEPTH - 1,
  parameter int AE_LEVEL = 1,
  localparam int AW = clog2(DEPTH)
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              EN,
  input  logic              WR,
  input  logic              RD,
  input  logic [DATA_W-1:0] dataIn,
  output logic [DATA_W-1:0] dataOut,
  output logic              EMPTY,
  output logic              FULL,
  output logic              ALMOST_EMPTY,
  output logic              ALMOST_FULL,
`ifdef PARAM_FIFO_ERR_FLAGS_EN
  output logic              OVERFLOW,
  output logic              UNDERFLOW,
`endif
  output logic [AW:0]       COUNT
);
  logic [AW:0] wr_ptr, rd_ptr, wr_nxt, rd_nxt, count_nxt;
  logic rd_ok, wr_ok, out_vld;
  logic [DATA_W-1:0] mem_q;
  assign rd_ok = EN & RD & ~EMPTY;
  assign wr_ok = EN & WR & (~FULL | rd_ok);
  // Next pointers; the wrap bit keeps the difference exact from 0 to DEPTH
  always_comb begin
    wr_nxt = wr_ptr + (AW+1)'(wr_ok);
    rd_nxt = rd_ptr + (AW+1)'(rd_ok);
    count_nxt = wr_nxt - rd_nxt;
  end
  fifo_mem #(.DATA_W(DATA_W), .AW(AW)) u_mem (
    .Clk(Clk),
    .we(wr_ok),
    .wa(wr_ptr[AW-1:0]),
    .wd(dataIn),
    .re(rd_ok),
    .ra(rd_ptr[AW-1:0]),
    .rd(mem_q)
  );
  // Until the first read after reset, the unreset array output is masked to zero
  assign dataOut = out_vld ? mem_q : '0;
  // Pointers, occupancy and flags registered together so they always agree
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      COUNT <= '0;
      out_vld <= 1'b0;
      EMPTY <= 1'b1;
      FULL <= 1'b0;
      ALMOST_EMPTY <= (AE_LEVEL >= 0);
      ALMOST_FULL <= (AF_LEVEL <= 0);
    end else begin
      wr_ptr <= wr_nxt;
      rd_ptr <= rd_nxt;
      COUNT <= count_nxt;
      out_vld <= out_vld | rd_ok;
      EMPTY <= count_nxt == '0;
      FULL <= count_nxt == (AW+1)'(DEPTH);
      ALMOST_EMPTY <= int'(count_nxt) <= AE_LEVEL;
      ALMOST_FULL <= int'(count_nxt) >= AF_LEVEL;
    end
  end
`ifdef PARAM_FIFO_ERR_FLAGS_EN
  // Sticky error flags for rejected requests, cleared only by reset
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      OVERFLOW <= 1'b0;
      UNDERFLOW <= 1'b0;
    end else begin
      OVERFLOW <= OVERFLOW | (EN & WR & FULL & ~rd_ok);
      UNDERFLOW <= UNDERFLOW | (EN & RD & EMPTY);
    end
  end
`endif
endmodule

// File: tb/tb_param_fifo_buffer.sv
// tb_param_fifo_buffer: directed checks of param_fifo_buffer at DATA_W=32, DEPTH=8
module tb_param_fifo_buffer;
  logic Clk = 1'b0;
  logic Rst = 1'b1;
  logic EN = 1'b0;
  logic WR = 1'b0;
  logic RD = 1'b0;
  logic [31:0] dataIn = '0;
  logic [31:0] dataOut;
  logic EMPTY, FULL, ALMOST_EMPTY, ALMOST_FULL;
  logic [3:0] COUNT;
`ifdef PARAM_FIFO_ERR_FLAGS_EN
  logic OVERFLOW, UNDERFLOW;
`endif
  int n_chk = 0;
  int n_fail = 0;
  param_fifo_buffer #(.DATA_W(32), .DEPTH(8), .AF_LEVEL(7), .AE_LEVEL(1)) dut (
    .Clk(Clk),
    .Rst(Rst),
    .EN(EN),
    .WR(WR),
    .RD(RD),
    .dataIn(dataIn),
    .dataOut(dataOut),
    .EMPTY(EMPTY),
    .FULL(FULL),
    .ALMOST_EMPTY(ALMOST_EMPTY),
    .ALMOST_FULL(ALMOST_FULL),
`ifdef PARAM_FIFO_ERR_FLAGS_EN
    .OVERFLOW(OVERFLOW),
    .UNDERFLOW(UNDERFLOW),
`endif
    .COUNT(COUNT)
  );
  always #5 Clk = ~Clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic op(input logic en, input logic wr, input logic rd, input logic [31:0] d);
    EN = en;
    WR = wr;
    RD = rd;
    dataIn = d;
    @(posedge Clk);
    #1;
  endtask
  task automatic flags(input string tag, input int cnt, input logic e, input logic f, input logic ae, input logic af);
    check({tag, "_count"}, 64'(COUNT), 64'(cnt));
    check({tag, "_empty"}, 64'(EMPTY), 64'(e));
    check({tag, "_full"}, 64'(FULL), 64'(f));
    check({tag, "_aempty"}, 64'(ALMOST_EMPTY), 64'(ae));
    check({tag, "_afull"}, 64'(ALMOST_FULL), 64'(af));
  endtask
  initial begin
    #12;
    flags("reset", 0, 1, 0, 1, 0);
    check("reset_dout", 64'(dataOut), 0);
    Rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      op(1, 1, 0, 32'(i));
      if (i == 0) flags("wr1", 1, 0, 0, 1, 0);
      if (i == 1) check("wr2_aempty", 64'(ALMOST_EMPTY), 0);
    end
    flags("wr5", 5, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      op(1, 0, 1, 32'hdead);
      check($sformatf("rd%0d_dout", i), 64'(dataOut), 64'(i));
    end
    op(1, 0, 0, 32'h0);
    flags("drained", 0, 1, 0, 1, 0);
    check("hold_dout", 64'(dataOut), 4);
    for (int i = 0; i < 9; i++) begin
      op(1, 1, 0, 32'h10 + 32'(i));
      if (i == 6) flags("wr7", 7, 0, 0, 0, 1);
      if (i == 7) flags("wr8", 8, 0, 1, 0, 1);
    end
    flags("overwr", 8, 0, 1, 0, 1);
`ifdef PARAM_FIFO_ERR_FLAGS_EN
    check("overflow", 64'(OVERFLOW), 1);
    check("underflow_clr", 64'(UNDERFLOW), 0);
`endif
    op(1, 1, 1, 32'h99);
    check("full_rw_dout", 64'(dataOut), 'h10);
    flags("full_rw", 8, 0, 1, 0, 1);
    for (int i = 0; i < 8; i++) begin
      op(1, 0, 1, 32'h0);
      check($sformatf("full_rd%0d", i), 64'(dataOut), i == 7 ? 64'h99 : 64'h11 + 64'(i));
    end
    flags("empty2", 0, 1, 0, 1, 0);
    op(1, 0, 1, 32'h0);
    check("underrd_dout", 64'(dataOut), 'h99);
    check("underrd_count", 64'(COUNT), 0);
`ifdef PARAM_FIFO_ERR_FLAGS_EN
    check("underflow", 64'(UNDERFLOW), 1);
`endif
    op(0, 1, 0, 32'h77);
    flags("en_off", 0, 1, 0, 1, 0);
    op(1, 1, 1, 32'h100);
    check("empty_rw_count", 64'(COUNT), 1);
    check("empty_rw_dout", 64'(dataOut), 'h99);
    for (int i = 1; i < 12; i++) begin
      op(1, 1, 1, 32'h100 + 32'(i));
      check($sformatf("wrap%0d_dout", i), 64'(dataOut), 64'h100 + 64'(i - 1));
      check($sformatf("wrap%0d_count", i), 64'(COUNT), 1);
    end
    op(1, 0, 1, 32'h0);
    check("wrap_last", 64'(dataOut), 'h10b);
    for (int i = 0; i < 3; i++) op(1, 1, 0, 32'h200 + 32'(i));
    EN = 1'b0;
    WR = 1'b0;
    check("pre_rst_count", 64'(COUNT), 3);
    #2;
    Rst = 1'b1;
    #1;
    flags("async_rst", 0, 1, 0, 1, 0);
    check("async_rst_dout", 64'(dataOut), 0);
    #2;
    Rst = 1'b0;
    @(posedge Clk);
    #1;
    op(1, 1, 0, 32'h55);
    check("post_rst_count", 64'(COUNT), 1);
    op(1, 0, 1, 32'h0);
    check("post_rst_dout", 64'(dataOut), 'h55);
    flags("post_rst", 0, 1, 0, 1, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
